debounce_multi: RTL and testbench
=================================

DEBOUNCE_MULTI -- requirements
Module: debounce_multi

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 4, meaning the number of independent button channels (>=1).
REQ-002 The block SHALL have parameter STABLE_CYCLES, default 4, meaning the consecutive synchronised cycles a new level must persist before acceptance (>=1).
REQ-003 The block SHALL have parameter HOLD_CYCLES, default 16, meaning the debounced-high cycles before a hold event (>=1).
REQ-004 The block SHALL have parameter REPEAT, default 0, meaning 0 gives one hold pulse per press and 1 repeats the hold pulse every HOLD_CYCLES while held.
REQ-005 The block SHALL have parameter INVERT, default 0, meaning 1 treats raw inputs as active-low.
REQ-006 The block SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-007 The block SHALL have port reset  input  1  synchronous, active-low reset.
REQ-008 The block SHALL have port button  input  CHANNELS  raw asynchronous button levels.
REQ-009 The block SHALL have port debounced  output  CHANNELS  clean level per channel (1 = pressed).
REQ-010 The block SHALL have port rise  output  CHANNELS  one-cycle press pulse.
REQ-011 The block SHALL have port fall  output  CHANNELS  one-cycle release pulse.
REQ-012 The block SHALL have port hold  output  CHANNELS  one-cycle long-press pulse.

Function
REQ-013 Each channel SHALL pass button through a 2-flop synchronizer, then XOR with INVERT, giving s[i].
REQ-014 Channels SHALL be fully independent: no shared counters, no cross-channel interaction.
REQ-015 Per-channel stable counter SHALL be wide enough for STABLE_CYCLES-1, with no overflow.
REQ-016 Each edge: if s[i]==debounced[i], counter SHALL clear to 0.
REQ-017 Each edge: if s[i]!=debounced[i] and counter==STABLE_CYCLES-1, debounced[i] SHALL take s[i] and counter SHALL clear.
REQ-018 Otherwise (s[i] differs, counter below limit) counter SHALL increment by 1.
REQ-019 Latency: a clean raw change first sampled on edge E0 SHALL appear on debounced at edge E0+STABLE_CYCLES+1, i.e. STABLE_CYCLES+2 edges inclusive (6 with defaults).
REQ-020 A level shorter than STABLE_CYCLES synchronised cycles SHALL produce no debounced change and no pulses.
REQ-021 Each bounce back to the current debounced level SHALL restart the count from 0.
REQ-022 rise[i] SHALL be high exactly in the first cycle debounced[i] is 1, and fall[i] exactly in the first cycle debounced[i] is 0 after being 1.
REQ-023 A per-channel hold counter SHALL clear in the rise cycle and count cycles while debounced[i]=1.
REQ-024 hold[i] SHALL pulse for one cycle exactly HOLD_CYCLES cycles after the rise[i] cycle.
REQ-025 With REPEAT=0, the hold counter SHALL saturate after the pulse, giving at most one hold per press.
REQ-026 With REPEAT=1, the hold counter SHALL wrap so that hold repeats every HOLD_CYCLES cycles while pressed.
REQ-027 If debounced[i] falls, the hold counter SHALL clear, and no hold SHALL occur in or after the fall cycle.
REQ-028 rise, fall and hold SHALL all be driven from registers, with no combinational path from button.
REQ-029 Simultaneous events on different channels SHALL each be reported in the same cycle.

Reset
REQ-030 While reset=0 at an edge, the synchronizer flops SHALL load INVERT.
REQ-031 While reset=0 at an edge, all counters SHALL clear and debounced, rise, fall and hold SHALL be 0.
REQ-032 Reset mid-count or mid-press SHALL discard all progress with no pulse emitted.
REQ-033 After reset release, the block SHALL treat the input as a fresh change.
REQ-034 A button already pressed through reset SHALL give rise STABLE_CYCLES+2 edges after release.

Verification (CHANNELS=4, STABLE_CYCLES=4, HOLD_CYCLES=16, INVERT=0 unless noted)
REQ-035 Bench SHALL cover: reset=0 for 3 cycles with button=4'hF -> all outputs 0 during reset; debounced=4'hF and rise=4'hF single cycle on the 6th edge after release.
REQ-036 Bench SHALL cover: button[0] high 12 cycles then low -> debounced[0] rises 6 edges after press, one rise[0]; falls 6 edges after release, one fall[0]; hold[0] never.
REQ-037 Bench SHALL cover: button[1] high for 3 cycles only, plus button[2] toggling 1,0,1,0 then steady 1 -> channel 1 silent; channel 2 debounced 6 edges after last transition, exactly one rise[2].
REQ-038 Bench SHALL cover: button[3] held 40 cycles, REPEAT=0 -> one hold[3] 16 cycles after rise[3]; rerun with REPEAT=1 -> hold[3] at +16 and +32.
REQ-039 Bench SHALL cover: button[0] released and button[1] pressed on the same edge, both previously stable -> fall[0] and rise[1] in the same cycle.
REQ-040 Bench SHALL cover: reset=0 asserted when the ch0 counter is 2 -> no pulses; debounced[0] 0; rerun INVERT=1 with button=4'hF idle -> all outputs stay 0.

Source files
------------

// File: rtl/debounce_multi.sv
// Multi-channel button debouncer: 2-flop synchroniser, per-channel stability counter,
// registered press/release pulses and a long-press (hold) pulse with optional repeat.
module debounce_multi #(
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES   = 16,
    parameter bit          REPEAT        = 1'b0,
    parameter bit          INVERT        = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] button,
    output logic [CHANNELS-1:0] debounced,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] hold
);

    localparam int unsigned StW   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);

    localparam logic [StW-1:0]      StLimit  = StW'(STABLE_CYCLES - 1);
    localparam logic [HoldW-1:0]    HoldLast = HoldW'(HOLD_CYCLES - 1);
    localparam logic [HoldW-1:0]    HoldSat  = HoldW'(HOLD_CYCLES);
    localparam logic [CHANNELS-1:0] InvMask  = {CHANNELS{INVERT}};

    logic [CHANNELS-1:0] sync1_q;
    logic [CHANNELS-1:0] sync2_q;
    logic [CHANNELS-1:0] s;

    // Synchroniser idles at the inactive raw level so reset looks like "not pressed".
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= InvMask;
            sync2_q <= InvMask;
        end else begin
            sync1_q <= button;
            sync2_q <= sync1_q;
        end
    end

    assign s = sync2_q ^ InvMask;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [StW-1:0]   stab_q, stab_d;
        logic [HoldW-1:0] hcnt_q, hcnt_d;
        logic             deb_q, deb_d;
        logic             rise_q, rise_d;
        logic             fall_q, fall_d;
        logic             hold_q, hold_d;

        always_comb begin
            stab_d = stab_q;
            deb_d  = deb_q;
            if (s[i] == deb_q) begin
                stab_d = '0;
            end else if (stab_q == StLimit) begin
                deb_d  = s[i];
                stab_d = '0;
            end else begin
                stab_d = stab_q + 1'b1;
            end

            rise_d = deb_d & ~deb_q;
            fall_d = ~deb_d & deb_q;

            // Hold counter is zero in the rise cycle; a release wins over a due hold.
            hold_d = 1'b0;
            hcnt_d = hcnt_q;
            if (!deb_d || rise_d) begin
                hcnt_d = '0;
            end else if (hcnt_q == HoldLast) begin
                hold_d = 1'b1;
                hcnt_d = REPEAT ? '0 : HoldSat;
            end else if (hcnt_q != HoldSat) begin
                hcnt_d = hcnt_q + 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (!reset) begin
                stab_q <= '0;
                hcnt_q <= '0;
                deb_q  <= 1'b0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                hold_q <= 1'b0;
            end else begin
                stab_q <= stab_d;
                hcnt_q <= hcnt_d;
                deb_q  <= deb_d;
                rise_q <= rise_d;
                fall_q <= fall_d;
                hold_q <= hold_d;
            end
        end

        assign debounced[i] = deb_q;
        assign rise[i]      = rise_q;
        assign fall[i]      = fall_q;
        assign hold[i]      = hold_q;
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Scoreboard bench for debounce_multi: three instances (default, REPEAT=1, INVERT=1) with
// expected pulse events queued by the stimulus and checked by a negedge monitor.
module tb_debounce_multi;

    typedef struct {
        int unsigned edge_no;
        logic [3:0]  r;
        logic [3:0]  f;
        logic [3:0]  h;
        logic [3:0]  db;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn_a, btn_b, btn_c;
    logic [3:0] deb_a, rise_a, fall_a, hold_a;
    logic [3:0] deb_b, rise_b, fall_b, hold_b;
    logic [3:0] deb_c, rise_c, fall_c, hold_c;

    int unsigned edge_n = 0;
    int          n_cmp  = 0;
    int          n_bad  = 0;
    ev_t         evq [3][$];

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    debounce_multi #(.CHANNELS(4), .STABLE_CYCLES(4), .HOLD_CYCLES(16), .REPEAT(1'b0),
                     .INVERT(1'b0)) u_dut_a (
        .clk(clk), .reset(reset), .button(btn_a),
        .debounced(deb_a), .rise(rise_a), .fall(fall_a), .hold(hold_a)
    );

    debounce_multi #(.CHANNELS(4), .STABLE_CYCLES(4), .HOLD_CYCLES(16), .REPEAT(1'b1),
                     .INVERT(1'b0)) u_dut_b (
        .clk(clk), .reset(reset), .button(btn_b),
        .debounced(deb_b), .rise(rise_b), .fall(fall_b), .hold(hold_b)
    );

    debounce_multi #(.CHANNELS(4), .STABLE_CYCLES(4), .HOLD_CYCLES(16), .REPEAT(1'b0),
                     .INVERT(1'b1)) u_dut_c (
        .clk(clk), .reset(reset), .button(btn_c),
        .debounced(deb_c), .rise(rise_c), .fall(fall_c), .hold(hold_c)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @edge %0d: got %0h, expected %0h", name, edge_n, act, exp);
        end
    endtask

    task automatic push(input int d, input int unsigned e, input logic [3:0] r,
                        input logic [3:0] f, input logic [3:0] h, input logic [3:0] db);
        ev_t ev;
        ev.edge_no = e;
        ev.r = r;
        ev.f = f;
        ev.h = h;
        ev.db = db;
        evq[d].push_back(ev);
    endtask

    task automatic mon(input int d, input logic [3:0] r, input logic [3:0] f,
                       input logic [3:0] h, input logic [3:0] db);
        ev_t ev;
        if ((r | f | h) != 4'd0) begin
            if (evq[d].size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pulse dut%0d @edge %0d: rise=%h fall=%h hold=%h, expected none",
                         d, edge_n, r, f, h);
            end else begin
                ev = evq[d].pop_front();
                check($sformatf("dut%0d_event_edge", d), edge_n, ev.edge_no);
                check($sformatf("dut%0d_rise", d), 32'(r), 32'(ev.r));
                check($sformatf("dut%0d_fall", d), 32'(f), 32'(ev.f));
                check($sformatf("dut%0d_hold", d), 32'(h), 32'(ev.h));
                check($sformatf("dut%0d_debounced", d), 32'(db), 32'(ev.db));
            end
        end
    endtask

    always @(negedge clk) begin
        if (edge_n >= 1) begin
            mon(0, rise_a, fall_a, hold_a, deb_a);
            mon(1, rise_b, fall_b, hold_b, deb_b);
            mon(2, rise_c, fall_c, hold_c, deb_c);
        end
    end

    task automatic wait_edge(input int unsigned n);
        while (edge_n < n) @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_a"}, 32'({deb_a, rise_a, fall_a, hold_a}), 32'd0);
        check({tag, "_b"}, 32'({deb_b, rise_b, fall_b, hold_b}), 32'd0);
        check({tag, "_c"}, 32'({deb_c, rise_c, fall_c, hold_c}), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Pressed through reset: fresh change after release.
        reset = 1'b0;
        btn_a = 4'hF;
        btn_b = 4'h0;
        btn_c = 4'hF;
        for (int i = 1; i <= 3; i++) begin
            wait_edge(i);
            chk_zero("in_reset");
        end
        reset = 1'b1;
        push(0, 9, 4'hF, 4'h0, 4'h0, 4'hF);
        push(0, 25, 4'h0, 4'h0, 4'hF, 4'hF);
        wait_edge(8);
        check("deb_a_before_latency", 32'(deb_a), 32'h0);
        wait_edge(9);
        check("deb_a_at_latency", 32'(deb_a), 32'hF);
        wait_edge(27);
        btn_a = 4'h0;
        push(0, 33, 4'h0, 4'hF, 4'h0, 4'h0);

        // Short press on ch0: rise/fall, no hold.
        wait_edge(40);
        btn_a[0] = 1'b1;
        push(0, 46, 4'h1, 4'h0, 4'h0, 4'h1);
        wait_edge(45);
        check("deb_a_press_minus1", 32'(deb_a), 32'h0);
        wait_edge(52);
        btn_a[0] = 1'b0;
        push(0, 58, 4'h0, 4'h1, 4'h0, 4'h0);
        wait_edge(57);
        check("deb_a_release_minus1", 32'(deb_a), 32'h1);

        // Glitch on ch1 (one cycle short) and bounce on ch2.
        wait_edge(70);
        btn_a[1] = 1'b1;
        btn_a[2] = 1'b1;
        wait_edge(71);
        btn_a[2] = 1'b0;
        wait_edge(72);
        btn_a[2] = 1'b1;
        wait_edge(73);
        btn_a[1] = 1'b0;
        btn_a[2] = 1'b0;
        wait_edge(74);
        btn_a[2] = 1'b1;
        push(0, 80, 4'h4, 4'h0, 4'h0, 4'h4);
        wait_edge(79);
        check("deb_a_bounce_minus1", 32'(deb_a), 32'h0);
        wait_edge(85);
        btn_a[2] = 1'b0;
        push(0, 91, 4'h0, 4'h4, 4'h0, 4'h0);

        // Long press on ch3: single hold vs repeating hold.
        wait_edge(100);
        btn_a[3] = 1'b1;
        btn_b[3] = 1'b1;
        push(0, 106, 4'h8, 4'h0, 4'h0, 4'h8);
        push(0, 122, 4'h0, 4'h0, 4'h8, 4'h8);
        push(1, 106, 4'h8, 4'h0, 4'h0, 4'h8);
        push(1, 122, 4'h0, 4'h0, 4'h8, 4'h8);
        push(1, 138, 4'h0, 4'h0, 4'h8, 4'h8);
        wait_edge(140);
        btn_a[3] = 1'b0;
        btn_b[3] = 1'b0;
        push(0, 146, 4'h0, 4'h8, 4'h0, 4'h0);
        push(1, 146, 4'h0, 4'h8, 4'h0, 4'h0);

        // Simultaneous release of ch0 and press of ch1; ch0 falls one cycle before its hold.
        wait_edge(150);
        btn_a[0] = 1'b1;
        push(0, 156, 4'h1, 4'h0, 4'h0, 4'h1);
        wait_edge(165);
        btn_a[0] = 1'b0;
        btn_a[1] = 1'b1;
        push(0, 171, 4'h2, 4'h1, 4'h0, 4'h2);
        wait_edge(175);
        btn_a[1] = 1'b0;
        push(0, 181, 4'h0, 4'h2, 4'h0, 4'h0);

        // Reset while the ch0 stability counter is at 2.
        wait_edge(190);
        btn_a[0] = 1'b1;
        wait_edge(194);
        reset = 1'b0;
        btn_a[0] = 1'b0;
        wait_edge(195);
        chk_zero("mid_count_reset");
        wait_edge(196);
        chk_zero("mid_count_reset2");
        reset = 1'b1;
        wait_edge(200);
        check("deb_a_after_reset", 32'(deb_a), 32'h0);
        wait_edge(215);
        check("deb_a_final", 32'(deb_a), 32'h0);
        check("deb_c_inverted_idle", 32'(deb_c), 32'h0);
        check("dut0_pending_events", evq[0].size(), 32'd0);
        check("dut1_pending_events", evq[1].size(), 32'd0);
        check("dut2_pending_events", evq[2].size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
